multicycle_mips_core: RTL and testbench



---
 rtl/multicycle_mips_core.sv | 192 +++++++++++++++++++
 tb/tb_multicycle_mips_core.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_mips_core.sv
// Multi-cycle MIPS-subset core: FSM controller and datapath sharing one
// ready-handshaked memory port for instruction fetch and data access.
module multicycle_mips_core #(
  parameter int unsigned              ADDRESS_WIDTH = 32,
  parameter int unsigned              DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
  input  logic                     CLK,
  input  logic                     rst,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  input  logic                     mem_ready,
  output logic [ADDRESS_WIDTH-1:0] PC,
  output logic                     instr_done,
  output logic                     illegal_op
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // Jump keeps PC bits above bit 27; mask form stays legal at ADDRESS_WIDTH == 28.
  localparam logic [ADDRESS_WIDTH-1:0] PC_LOW28 = ADDRESS_WIDTH'({28{1'b1}});

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXEC, S_ALUWB, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP
  } state_t;

  state_t                   r_state;
  logic [ADDRESS_WIDTH-1:0] r_pc;
  logic [31:0]              r_ir;
  logic [DATA_WIDTH-1:0]    r_mdr;
  logic [DATA_WIDTH-1:0]    r_a;
  logic [DATA_WIDTH-1:0]    r_b;
  logic [DATA_WIDTH-1:0]    r_aluout;
  logic [DATA_WIDTH-1:0]    r_regs [32];

  logic [5:0]               w_op;
  logic [5:0]               w_funct;
  logic [4:0]               w_rs;
  logic [4:0]               w_rt;
  logic [4:0]               w_rd;
  logic [DATA_WIDTH-1:0]    w_simm;
  logic [DATA_WIDTH-1:0]    w_alu_r;
  logic                     w_op_legal;
  logic                     w_funct_legal;
  logic [ADDRESS_WIDTH-1:0] w_pc_plus4;
  logic [ADDRESS_WIDTH-1:0] w_jump_target;
  logic [ADDRESS_WIDTH-1:0] w_alu_addr;

  assign w_op    = r_ir[31:26];
  assign w_rs    = r_ir[25:21];
  assign w_rt    = r_ir[20:16];
  assign w_rd    = r_ir[15:11];
  assign w_funct = r_ir[5:0];
  assign w_simm  = {{(DATA_WIDTH-16){r_ir[15]}}, r_ir[15:0]};

  assign w_pc_plus4    = r_pc + ADDRESS_WIDTH'(4);
  assign w_jump_target = (r_pc & ~PC_LOW28) | ADDRESS_WIDTH'({r_ir[25:0], 2'b00});
  assign w_alu_addr    = ADDRESS_WIDTH'(r_aluout);

  always_comb begin
    case (w_op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: w_op_legal = 1'b1;
      default:                                       w_op_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_funct_legal = 1'b1;
    w_alu_r       = '0;
    case (w_funct)
      FN_ADD:  w_alu_r = r_a + r_b;
      FN_SUB:  w_alu_r = r_a - r_b;
      FN_AND:  w_alu_r = r_a & r_b;
      FN_OR:   w_alu_r = r_a | r_b;
      FN_SLT:  w_alu_r = ($signed(r_a) < $signed(r_b)) ? DATA_WIDTH'(1) : '0;
      default: w_funct_legal = 1'b0;
    endcase
  end

  assign mem_req   = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
  assign mem_we    = (r_state == S_MEMWR);
  assign mem_addr  = (r_state == S_FETCH) ? r_pc : w_alu_addr;
  assign mem_wdata = r_b;
  assign PC        = r_pc;

  assign illegal_op = ((r_state == S_DECODE) && !w_op_legal) ||
                      ((r_state == S_EXEC)   && !w_funct_legal);

  always_comb begin
    case (r_state)
      S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP: instr_done = 1'b1;
      S_MEMWR:  instr_done = mem_ready;
      S_DECODE: instr_done = !w_op_legal;
      S_EXEC:   instr_done = !w_funct_legal;
      default:  instr_done = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      r_state  <= S_FETCH;
      r_pc     <= RESET_PC;
      r_ir     <= '0;
      r_mdr    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_aluout <= '0;
      for (int unsigned i = 0; i < 32; i++) r_regs[i] <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (mem_ready) begin
            r_ir    <= 32'(mem_rdata);
            r_pc    <= w_pc_plus4;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_a      <= r_regs[w_rs];
          r_b      <= r_regs[w_rt];
          r_aluout <= DATA_WIDTH'(r_pc) + (w_simm << 2);
          case (w_op)
            OP_LW, OP_SW: r_state <= S_MEMADR;
            OP_RTYPE:     r_state <= S_EXEC;
            OP_ADDI:      r_state <= S_ADDIEX;
            OP_BEQ:       r_state <= S_BRANCH;
            OP_J:         r_state <= S_JUMP;
            default:      r_state <= S_FETCH;
          endcase
        end
        S_MEMADR: begin
          r_aluout <= r_a + w_simm;
          r_state  <= (w_op == OP_LW) ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD: begin
          if (mem_ready) begin
            r_mdr   <= mem_rdata;
            r_state <= S_MEMWB;
          end
        end
        S_MEMWB: begin
          if (w_rt != 5'd0) r_regs[w_rt] <= r_mdr;
          r_state <= S_FETCH;
        end
        S_MEMWR: begin
          if (mem_ready) r_state <= S_FETCH;
        end
        S_EXEC: begin
          r_aluout <= w_alu_r;
          r_state  <= w_funct_legal ? S_ALUWB : S_FETCH;
        end
        S_ALUWB: begin
          if (w_rd != 5'd0) r_regs[w_rd] <= r_aluout;
          r_state <= S_FETCH;
        end
        S_ADDIEX: begin
          r_aluout <= r_a + w_simm;
          r_state  <= S_ADDIWB;
        end
        S_ADDIWB: begin
          if (w_rt != 5'd0) r_regs[w_rt] <= r_aluout;
          r_state <= S_FETCH;
        end
        S_BRANCH: begin
          if (r_a == r_b) r_pc <= w_alu_addr;
          r_state <= S_FETCH;
        end
        S_JUMP: begin
          r_pc    <= w_jump_target;
          r_state <= S_FETCH;
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_mips_core.sv
// Scoreboard bench for multicycle_mips_core: a directed program in a bench
// memory with wait states; instruction and store expectations are queued.
module tb_multicycle_mips_core;

  localparam logic [31:0] RPC     = 32'h0;
  localparam logic [31:0] STALL_A = 32'h124;
  localparam int unsigned BUDGET  = 2000;

  logic        CLK = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready = 1'b0;
  logic [31:0] PC;
  logic        instr_done;
  logic        illegal_op;

  always #5 CLK = ~CLK;

  multicycle_mips_core #(
    .ADDRESS_WIDTH(32),
    .DATA_WIDTH   (32),
    .RESET_PC     (RPC)
  ) dut (
    .CLK       (CLK),
    .rst       (rst),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .PC        (PC),
    .instr_done(instr_done),
    .illegal_op(illegal_op)
  );

  logic [31:0] mem [0:1023];
  assign mem_rdata = mem[mem_addr[11:2]];

  typedef struct { int unsigned len; bit ill; logic [31:0] npc; } irec_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; } wrec_t;
  irec_t iq[$];
  wrec_t wq[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ei(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] er(input logic [4:0] rs, input logic [4:0] rt,
                                     input logic [4:0] rd, input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, 5'b00000, fn};
  endfunction

  function automatic logic [31:0] ej(input logic [25:0] t);
    return {6'b000010, t};
  endfunction

  task automatic put(input logic [31:0] addr, input logic [31:0] word,
                     input int unsigned len, input bit ill, input logic [31:0] npc);
    irec_t r;
    mem[addr[11:2]] = word;
    r.len = len; r.ill = ill; r.npc = npc;
    iq.push_back(r);
  endtask

  task automatic exp_wr(input logic [31:0] addr, input logic [31:0] data);
    wrec_t w;
    w.addr = addr; w.data = data;
    wq.push_back(w);
  endtask

  // Memory responder: data accesses wait 2 cycles (STALL_A effectively forever),
  // fetch at 0x2C waits 1; ready is driven high while no request is pending.
  int unsigned wcnt = 0;
  function automatic int unsigned need_for(input logic [31:0] a, input logic [31:0] pc);
    if (a != pc) return (a == STALL_A) ? 50 : 2;
    return (a == 32'h2C) ? 1 : 0;
  endfunction

  always begin
    @(posedge CLK);
    #1;
    if (!mem_req) begin
      mem_ready = 1'b1;
      wcnt      = 0;
    end else begin
      if (mem_ready) wcnt = 0;
      mem_ready = (wcnt >= need_for(mem_addr, PC));
      if (!mem_ready) wcnt++;
    end
  end

  // Monitor: pops expectations whenever the core retires an instruction or a store.
  int unsigned cyc = 0;
  bit          npc_v = 1'b0;
  logic [31:0] npc_exp;
  bit          stall_v = 1'b0;
  logic [31:0] st_addr, st_wdata;
  logic        st_we;
  irec_t       mr;
  wrec_t       mw;

  always @(negedge CLK) begin
    if (rst) begin
      cyc = 0; npc_v = 1'b0; stall_v = 1'b0;
    end else begin
      cyc++;
      if (npc_v) begin
        chk("next_pc", PC, npc_exp);
        npc_v = 1'b0;
      end
      if (stall_v) begin
        chk("hold_addr", mem_addr, st_addr);
        chk("hold_we", 32'(mem_we), 32'(st_we));
        if (st_we) chk("hold_wdata", mem_wdata, st_wdata);
      end
      stall_v  = mem_req && !mem_ready;
      st_addr  = mem_addr;
      st_we    = mem_we;
      st_wdata = mem_wdata;
      if (mem_req && mem_we && mem_ready) begin
        if (wq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: addr 0x%08h data 0x%08h, no write expected", mem_addr, mem_wdata);
        end else begin
          mw = wq.pop_front();
          chk("wr_addr", mem_addr, mw.addr);
          chk("wr_data", mem_wdata, mw.data);
        end
        mem[mem_addr[11:2]] = mem_wdata;
      end
      if (instr_done || illegal_op) begin
        if (iq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: instr_done=%0b illegal_op=%0b at PC 0x%08h, none expected",
                   instr_done, illegal_op, PC);
        end else begin
          mr = iq.pop_front();
          chk("instr_done", 32'(instr_done), 32'd1);
          chk("instr_cycles", 32'(cyc), 32'(mr.len));
          chk("illegal_op", 32'(illegal_op), 32'(mr.ill));
          npc_exp = mr.npc;
          npc_v   = 1'b1;
        end
        cyc = 0;
      end
    end
  end

  initial begin
    int unsigned n;
    for (int i = 0; i < 1024; i++) mem[i] = '0;

    // Arithmetic chain
    put(32'h000, ei(6'b001000, 5'd0, 5'd1, 16'd5),    4, 1'b0, 32'h004);
    put(32'h004, ei(6'b001000, 5'd0, 5'd2, 16'hFFFD), 4, 1'b0, 32'h008);
    put(32'h008, er(5'd1, 5'd2, 5'd3, 6'b100000),     4, 1'b0, 32'h00C);
    put(32'h00C, er(5'd2, 5'd1, 5'd4, 6'b101010),     4, 1'b0, 32'h010);
    // Load/store with 2 wait cycles on each data access
    put(32'h010, ei(6'b101011, 5'd0, 5'd3, 16'h0008), 6, 1'b0, 32'h014);
    exp_wr(32'h008, 32'd2);
    put(32'h014, ei(6'b100011, 5'd0, 5'd5, 16'h0008), 7, 1'b0, 32'h018);
    put(32'h018, ei(6'b101011, 5'd0, 5'd5, 16'h0100), 6, 1'b0, 32'h01C);
    exp_wr(32'h100, 32'd2);
    put(32'h01C, ei(6'b101011, 5'd0, 5'd4, 16'h0104), 6, 1'b0, 32'h020);
    exp_wr(32'h104, 32'd1);
    // Branch taken, then not taken (its fetch has one wait cycle)
    put(32'h020, ei(6'b000100, 5'd1, 5'd1, 16'd2),    3, 1'b0, 32'h02C);
    put(32'h02C, ei(6'b000100, 5'd1, 5'd2, 16'd5),    4, 1'b0, 32'h030);
    // Jumps
    put(32'h030, ej(26'h0000010),                     3, 1'b0, 32'h040);
    put(32'h040, ej(26'h0000100),                     3, 1'b0, 32'h400);
    // Illegal opcode and illegal funct; neither may write r1 or r6
    put(32'h400, ei(6'b111111, 5'd1, 5'd1, 16'hFFFF), 2, 1'b1, 32'h404);
    put(32'h404, er(5'd1, 5'd2, 5'd6, 6'b000000),     3, 1'b1, 32'h408);
    put(32'h408, ei(6'b101011, 5'd0, 5'd6, 16'h0108), 6, 1'b0, 32'h40C);
    exp_wr(32'h108, 32'd0);
    put(32'h40C, ei(6'b101011, 5'd0, 5'd1, 16'h010C), 6, 1'b0, 32'h410);
    exp_wr(32'h10C, 32'd5);
    // Write to r0 is discarded
    put(32'h410, ei(6'b001000, 5'd0, 5'd0, 16'd7),    4, 1'b0, 32'h414);
    put(32'h414, ei(6'b101011, 5'd0, 5'd0, 16'h0110), 6, 1'b0, 32'h418);
    exp_wr(32'h110, 32'd0);
    // Remaining ALU ops
    put(32'h418, er(5'd2, 5'd1, 5'd7, 6'b100010),     4, 1'b0, 32'h41C);
    put(32'h41C, er(5'd1, 5'd2, 5'd8, 6'b100100),     4, 1'b0, 32'h420);
    put(32'h420, er(5'd1, 5'd2, 5'd9, 6'b100101),     4, 1'b0, 32'h424);
    put(32'h424, er(5'd1, 5'd2, 5'd10, 6'b101010),    4, 1'b0, 32'h428);
    put(32'h428, ei(6'b101011, 5'd0, 5'd7, 16'h0114), 6, 1'b0, 32'h42C);
    exp_wr(32'h114, 32'hFFFF_FFF8);
    put(32'h42C, ei(6'b101011, 5'd0, 5'd8, 16'h0118), 6, 1'b0, 32'h430);
    exp_wr(32'h118, 32'd5);
    put(32'h430, ei(6'b101011, 5'd0, 5'd9, 16'h011C), 6, 1'b0, 32'h434);
    exp_wr(32'h11C, 32'hFFFF_FFFD);
    put(32'h434, ei(6'b101011, 5'd0, 5'd10, 16'h0120), 6, 1'b0, 32'h438);
    exp_wr(32'h120, 32'd0);
    // Store that stalls; reset is asserted mid-access, so it never retires
    mem[32'h438 >> 2] = ei(6'b101011, 5'd0, 5'd1, STALL_A[15:0]);

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_mem_req",    32'(mem_req),    32'd1);
    chk("rst_mem_we",     32'(mem_we),     32'd0);
    chk("rst_mem_addr",   mem_addr,        RPC);
    chk("rst_pc",         PC,              RPC);
    chk("rst_instr_done", 32'(instr_done), 32'd0);
    chk("rst_illegal_op", 32'(illegal_op), 32'd0);
    @(posedge CLK);
    #2 rst = 1'b0;

    n = 0;
    while (!(mem_req && mem_we && mem_addr == STALL_A) && n < BUDGET) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (n >= BUDGET) begin
      errors++;
      $display("FAIL stall_reach: store to 0x%08h not seen within %0d cycles", STALL_A, BUDGET);
    end

    repeat (2) @(posedge CLK);
    #2 rst = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    chk("mid_rst_pc",       PC,                  RPC);
    chk("mid_rst_mem_req",  32'(mem_req),        32'd1);
    chk("mid_rst_mem_we",   32'(mem_we),         32'd0);
    chk("mid_rst_mem_addr", mem_addr,            RPC);
    chk("mid_rst_no_write", mem[STALL_A >> 2],   32'd0);
    chk("instr_queue_left", 32'(iq.size()),      32'd0);
    chk("write_queue_left", 32'(wq.size()),      32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
